// File: rtl/instr_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package instr_queue_pkg;

    localparam int IQ_BLK_W = 128;
    localparam int IQ_WORDS = 4;

    typedef struct packed {
        logic [IQ_BLK_W-1:0] data;
        logic [31:4]         pc_hi;
        logic [1:0]          start;
    } iq_entry_t;

endpackage

// File: rtl/instr_queue_sync_fifo.sv
// Generic synchronous FIFO exposing the head and the entry behind it,
// so a consumer can preload state for the next head without a bubble.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       clr_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [WIDTH-1:0]           next_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW-1:0]    w_rd_nxt_idx;

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !clr_i) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (wr_en_i) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (rd_en_i) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_comb begin
        w_rd_nxt_idx = r_rd_ptr[AW-1:0] + 1'b1;
        head_o       = r_mem[r_rd_ptr[AW-1:0]];
        next_o       = r_mem[w_rd_nxt_idx];
        count_o      = r_wr_ptr - r_rd_ptr;
        empty_o      = (r_wr_ptr == r_rd_ptr);
        full_o       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    end

endmodule

// File: rtl/instr_queue.sv
// Instruction queue: buffers 4-word fetch blocks and hands decode one
// instruction per cycle, skipping words before each block's start PC.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WORDS = IQ_WORDS
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IQ_BLK_W-1:0] blk_data_i,
    input  logic [31:0]         blk_pc_i,
    input  logic                blk_valid_i,
    output logic                blk_ready_o,
    output logic [31:0]         instr_o,
    output logic [31:0]         pc_o,
    output logic                valid_o,
    input  logic                deq_i,
    input  logic                flush_i
);

    localparam int EW = $bits(iq_entry_t);
    localparam int CW = $clog2(DEPTH) + 1;

    iq_entry_t       w_wr_entry;
    iq_entry_t       w_head;
    iq_entry_t       w_next;
    logic [EW-1:0]   w_head_bits;
    logic [EW-1:0]   w_next_bits;
    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_clr;
    logic            w_wr;
    logic            w_deq;
    logic            w_pop;
    logic [1:0]      r_woff;
    logic            w_unused_pc_lsb;

    assign w_unused_pc_lsb = ^blk_pc_i[1:0];

    always_comb begin
        w_wr_entry.data  = blk_data_i;
        w_wr_entry.pc_hi = blk_pc_i[31:4];
        w_wr_entry.start = blk_pc_i[3:2];
        w_head           = iq_entry_t'(w_head_bits);
        w_next           = iq_entry_t'(w_next_bits);
        w_clr            = rst_i || flush_i;
        blk_ready_o      = !w_full;
        valid_o          = !w_empty;
        w_wr             = blk_valid_i && !w_full;
        w_deq            = deq_i && !w_empty;
        w_pop            = w_deq && (r_woff == 2'd3);
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .clr_i     (w_clr),
        .wr_en_i   (w_wr),
        .wr_data_i (w_wr_entry),
        .rd_en_i   (w_pop),
        .head_o    (w_head_bits),
        .next_o    (w_next_bits),
        .count_o   (w_count),
        .full_o    (w_full),
        .empty_o   (w_empty)
    );

    // When the head retires with one block left, the successor is either
    // the block being written this very cycle or nothing at all.
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_woff <= '0;
        end else if (w_deq && (r_woff != 2'd3)) begin
            r_woff <= r_woff + 2'd1;
        end else if (w_pop) begin
            if (w_count >= CW'(2)) r_woff <= w_next.start;
            else if (w_wr)         r_woff <= w_wr_entry.start;
            else                   r_woff <= '0;
        end else if (w_empty && w_wr) begin
            r_woff <= w_wr_entry.start;
        end
    end

    always_comb begin
        instr_o = '0;
        pc_o    = '0;
        if (valid_o) begin
            instr_o = w_head.data[{r_woff, 5'b00000} +: 32];
            pc_o    = {w_head.pc_hi, r_woff, 2'b00};
        end
    end

endmodule
